// File: rtl/mat3_stream_bridge_pkg.sv
// mat3_stream_bridge_pkg: shared constants, FSM state encoding and the
// flattened-matrix element offset helper for the 3x3 stream bridge.
// Flattened layout: element [r][c] (idx = 3r+c) sits at
// bits [(8-idx)*ELEM_W +: ELEM_W], so [0][0] occupies the MSBs.
package mat3_stream_bridge_pkg;

  localparam int MAT_DIM   = 3;
  localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_CALC   = 2'd2,
    S_SEND   = 2'd3
  } state_t;

  // LSB position of row-major element idx inside a flattened matrix
  function automatic int elem_lsb(input int idx, input int ew);
    return (MAT_ELEMS - 1 - idx) * ew;
  endfunction

endpackage

// File: rtl/mat3_elem_serializer.sv
// mat3_elem_serializer: captures a flattened 3x3 matrix and emits its
// elements row-major from [0][0] as a valid/ready byte stream.
// Optional build macro MAT3_STREAM_CHECKSUM_EN adds a 10th beat carrying
// the XOR of the nine elements.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture word and start a burst (ignored rules: caller
//                   only pulses it while idle)
//   word            flattened matrix to send
//   out_data/out_valid/out_ready  element stream
//   done            last beat of the burst completes this cycle
module mat3_elem_serializer
  import mat3_stream_bridge_pkg::*;
#(
  parameter int ELEM_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [MAT_ELEMS*ELEM_W-1:0]   word,
  output logic [ELEM_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done
);

`ifdef MAT3_STREAM_CHECKSUM_EN
  localparam int NBEATS = MAT_ELEMS + 1;
`else
  localparam int NBEATS = MAT_ELEMS;
`endif

  logic [MAT_ELEMS*ELEM_W-1:0] res;
  logic [3:0]                  beat;
  logic                        vld;

  assign out_valid = vld;
  assign done      = vld & out_ready & (beat == 4'(NBEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      res  <= '0;
      beat <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      res  <= word;
      beat <= '0;
      vld  <= 1'b1;
    end else if (vld && out_ready) begin
      if (beat == 4'(NBEATS - 1)) begin
        vld  <= 1'b0;
        beat <= '0;
      end else begin
        beat <= beat + 4'd1;
      end
    end
  end

`ifdef MAT3_STREAM_CHECKSUM_EN
  logic [ELEM_W-1:0] cks;
  always_comb begin
    cks = '0;
    for (int i = 0; i < MAT_ELEMS; i++)
      cks = cks ^ res[elem_lsb(i, ELEM_W) +: ELEM_W];
  end
`endif

  // Output mux is driven purely from registered state, so out_data holds
  // while the downstream stalls.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < MAT_ELEMS; i++)
      if (beat == 4'(i)) out_data = res[elem_lsb(i, ELEM_W) +: ELEM_W];
`ifdef MAT3_STREAM_CHECKSUM_EN
    if (beat == 4'(MAT_ELEMS)) out_data = cks;
`endif
  end

endmodule

// File: rtl/mat3_stream_bridge.sv
// mat3_stream_bridge: byte-stream front/back end for a combinational 3x3
// matrix multiplier. Loads 9 elements of A then 9 of B (row-major) into the
// flattened operand buses, waits CALC_LAT cycles, captures the product and
// streams it back out as 9 elements (10 with MAT3_STREAM_CHECKSUM_EN).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_data/in_valid/in_ready   incoming element stream
//   mat_a, mat_b                flattened operands to multiplier
//   mat_c                       flattened product from multiplier
//   out_data/out_valid/out_ready outgoing element stream
//   busy                        low only when idle in LOAD_A with nothing loaded
module mat3_stream_bridge
  import mat3_stream_bridge_pkg::*;
#(
  parameter int ELEM_W   = 8,
  parameter int CALC_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ELEM_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [9*ELEM_W-1:0]    mat_a,
  output logic [9*ELEM_W-1:0]    mat_b,
  input  logic [9*ELEM_W-1:0]    mat_c,
  output logic [ELEM_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  state_t     state, state_nx;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       accept, cap, ser_done;

  assign busy = !(state == S_LOAD_A && idx == 4'd0);

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cap      = 1'b0;
    case (state)
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && idx == 4'(MAT_ELEMS - 1)) state_nx = S_LOAD_B;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && idx == 4'(MAT_ELEMS - 1)) state_nx = S_CALC;
      end
      S_CALC: begin
        // capture on the last settle cycle so the product has had CALC_LAT
        // cycles since the final operand write
        if (cnt == 4'(CALC_LAT - 1)) begin
          cap      = 1'b1;
          state_nx = S_SEND;
        end
      end
      S_SEND: begin
        if (ser_done) state_nx = S_LOAD_A;
      end
      default: state_nx = S_LOAD_A;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD_A;
      idx   <= '0;
      cnt   <= '0;
      mat_a <= '0;
      mat_b <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_CALC) ? cnt + 4'd1 : 4'd0;
      if (accept) begin
        for (int i = 0; i < MAT_ELEMS; i++)
          if (idx == 4'(i)) begin
            if (state == S_LOAD_A) mat_a[elem_lsb(i, ELEM_W) +: ELEM_W] <= in_data;
            else                   mat_b[elem_lsb(i, ELEM_W) +: ELEM_W] <= in_data;
          end
        idx <= (idx == 4'(MAT_ELEMS - 1)) ? 4'd0 : idx + 4'd1;
      end
    end
  end

  mat3_elem_serializer #(.ELEM_W(ELEM_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (cap),
    .word      (mat_c),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (ser_done)
  );

endmodule
